// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronizes PLL lock and external reset requests,
// releases SDRAM reset first, then system reset once SDRAM init completes.
//
// state         | meaning
// ST_HOLD       | both resets asserted, minimum hold time (stretched by ext request)
// ST_WAIT_LOCK  | both resets asserted, waiting for a continuous run of PLL lock
// ST_SDRAM_INIT | SDRAM reset released, waiting for init handshake or timeout
// ST_RUN        | all resets released until a fault event
module reset_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_RESET_CYCLES = 16,
  parameter int LOCK_CYCLES      = 1024,
  parameter int INIT_TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       ext_reset_req,
  input  logic       sdram_init_done,
  input  logic       cause_clear,
  output logic       sys_reset,
  output logic       sdram_reset,
  output logic [3:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam int HW = (MIN_RESET_CYCLES > 1) ? $clog2(MIN_RESET_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES > 1)      ? $clog2(LOCK_CYCLES)      : 1;
  localparam int IW = (INIT_TIMEOUT > 1)     ? $clog2(INIT_TIMEOUT)     : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_RESET_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_SDRAM_INIT,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [LW-1:0]          lock_q, lock_d;
  logic [IW-1:0]          init_q, init_d;
  logic [3:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic                   sys_reset_q, sdram_reset_q;
  logic [SYNC_STAGES-1:0] lock_sync_q, ext_sync_q;

  logic       locked_s, ext_s;
  logic       timeout;
  logic [3:0] cause_set;

  assign locked_s = lock_sync_q[SYNC_STAGES-1];
  assign ext_s    = ext_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    init_d    = init_q;
    cause_set = 4'b0000;
    timeout   = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (ext_s) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          lock_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (ext_s) begin
          cause_set[2] = 1'b1;
          state_d      = ST_HOLD;
          hold_d       = '0;
        end else if (!locked_s) begin
          lock_d = '0;
        end else if (lock_q == LOCK_LAST) begin
          state_d = ST_SDRAM_INIT;
          init_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      ST_SDRAM_INIT: begin
        // Completion on the timeout cycle suppresses the timeout; faults still win.
        timeout      = (init_q == INIT_LAST) && !sdram_init_done;
        cause_set[1] = !locked_s;
        cause_set[2] = ext_s;
        cause_set[3] = timeout;
        if (cause_set != 4'b0000) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (sdram_init_done) begin
          state_d = ST_RUN;
        end else if (init_q != INIT_LAST) begin
          init_d = init_q + 1'b1;
        end
      end
      ST_RUN: begin
        cause_set[1] = !locked_s;
        cause_set[2] = ext_s;
        if (cause_set != 4'b0000) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase

    cause_d = (cause_clear ? 4'b0000 : cause_q) | cause_set;
    count_d = count_q;
    if ((state_d == ST_HOLD) && (state_q != ST_HOLD) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      hold_q        <= '0;
      lock_q        <= '0;
      init_q        <= '0;
      cause_q       <= 4'b0001;
      count_q       <= 8'd0;
      sys_reset_q   <= 1'b1;
      sdram_reset_q <= 1'b1;
      lock_sync_q   <= '0;
      ext_sync_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      lock_q        <= lock_d;
      init_q        <= init_d;
      cause_q       <= cause_d;
      count_q       <= count_d;
      sys_reset_q   <= (state_d != ST_RUN);
      sdram_reset_q <= (state_d == ST_HOLD) || (state_d == ST_WAIT_LOCK);
      lock_sync_q   <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
      ext_sync_q    <= {ext_sync_q[SYNC_STAGES-2:0], ext_reset_req};
    end
  end

  assign sys_reset   = sys_reset_q;
  assign sdram_reset = sdram_reset_q;
  assign reset_cause = cause_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a phase/elapsed-time model.
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int MINR = 4;
  localparam int LOCK = 8;
  localparam int TMO  = 20;

  logic       clk;
  logic       reset_n, pll_locked, ext_reset_req, sdram_init_done, cause_clear;
  logic       sys_reset, sdram_reset;
  logic [3:0] reset_cause;
  logic [7:0] reset_count;

  int n_cmp = 0;
  int n_err = 0;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .MIN_RESET_CYCLES(MINR),
    .LOCK_CYCLES(LOCK), .INIT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .ext_reset_req(ext_reset_req), .sdram_init_done(sdram_init_done),
    .cause_clear(cause_clear), .sys_reset(sys_reset), .sdram_reset(sdram_reset),
    .reset_cause(reset_cause), .reset_count(reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n, pll, ext, done, clr;
    int         cycles;
    logic       e_sys, e_sdram;
    logic [3:0] e_cause;
    logic [7:0] e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic p, logic e, logic d, logic c,
                              int n, logic es, logic ed, logic [3:0] ec, logic [7:0] en);
    vec_t v;
    v.name = nm; v.rst_n = r; v.pll = p; v.ext = e; v.done = d; v.clr = c;
    v.cycles = n; v.e_sys = es; v.e_sdram = ed; v.e_cause = ec; v.e_count = en;
    return v;
  endfunction

  task automatic check(string nm, logic [13:0] exp);
    logic [13:0] act;
    act = {sys_reset, sdram_reset, reset_cause, reset_count};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got sys=%b sdram=%b cause=%b count=%0d, want sys=%b sdram=%b cause=%b count=%0d",
               nm, act[13], act[12], act[11:8], act[7:0], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: phase plus cycles elapsed in the current phase,
  // synchronizers as sample-history queues.
  localparam int PH_HOLD = 0, PH_LOCK = 1, PH_INIT = 2, PH_RUN = 3;
  int         m_ph, m_n, m_cnt;
  logic [3:0] m_cause;
  bit         m_lk[$], m_ex[$];

  task automatic model_reset();
    m_ph = PH_HOLD; m_n = 0; m_cnt = 0; m_cause = 4'b0001;
    m_lk.delete(); m_ex.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_lk.push_back(1'b0);
      m_ex.push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    bit ls, es, tmo_hit;
    int nxt;
    logic [3:0] set;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ls = m_lk[SYNC-1];
    es = m_ex[SYNC-1];
    m_lk.push_front(pll_locked); void'(m_lk.pop_back());
    m_ex.push_front(ext_reset_req); void'(m_ex.pop_back());
    set = 4'b0000;
    nxt = m_ph;
    case (m_ph)
      PH_HOLD:
        if (es) m_n = 0;
        else if (m_n + 1 >= MINR) nxt = PH_LOCK;
        else m_n++;
      PH_LOCK:
        if (es) begin set[2] = 1; nxt = PH_HOLD; end
        else if (!ls) m_n = 0;
        else if (m_n + 1 >= LOCK) nxt = PH_INIT;
        else m_n++;
      PH_INIT: begin
        tmo_hit = (m_n + 1 >= TMO) && !sdram_init_done;
        set[1] = !ls; set[2] = es; set[3] = tmo_hit;
        if (set != 0) nxt = PH_HOLD;
        else if (sdram_init_done) nxt = PH_RUN;
        else m_n++;
      end
      default: begin
        set[1] = !ls; set[2] = es;
        if (set != 0) nxt = PH_HOLD;
      end
    endcase
    if (nxt != m_ph) begin
      m_n = 0;
      if (nxt == PH_HOLD && m_cnt < 255) m_cnt++;
    end
    m_ph = nxt;
    m_cause = (cause_clear ? 4'b0000 : m_cause) | set;
  endtask

  initial begin
    bit ever_low;
    int low_left, pll_left, ext_left;
    logic [13:0] mexp;

    reset_n = 1'b0; pll_locked = 1'b1; ext_reset_req = 1'b0;
    sdram_init_done = 1'b0; cause_clear = 1'b0;

    //                name              rst pll ext done clr  n  sys sdr cause  cnt
    vecs.push_back(mk("reset",          0,  1,  0,  0,  0,   3, 1,  1, 4'b0001, 0));
    vecs.push_back(mk("pre_release",    1,  1,  0,  0,  0,  11, 1,  1, 4'b0001, 0));
    vecs.push_back(mk("sdram_rel_e12",  1,  1,  0,  0,  0,   1, 1,  0, 4'b0001, 0));
    vecs.push_back(mk("init_wait",      1,  1,  0,  0,  0,   2, 1,  0, 4'b0001, 0));
    vecs.push_back(mk("done_run",       1,  1,  0,  1,  0,   1, 0,  0, 4'b0001, 0));
    vecs.push_back(mk("run_steady",     1,  1,  0,  1,  0,   5, 0,  0, 4'b0001, 0));
    vecs.push_back(mk("lock_drop",      1,  0,  0,  1,  0,   1, 0,  0, 4'b0001, 0));
    vecs.push_back(mk("lock_drop_sync", 1,  1,  0,  1,  0,   1, 0,  0, 4'b0001, 0));
    vecs.push_back(mk("lockloss_hold",  1,  1,  0,  1,  0,   1, 1,  1, 4'b0011, 1));
    vecs.push_back(mk("reseq_hold",     1,  1,  0,  1,  0,  11, 1,  1, 4'b0011, 1));
    vecs.push_back(mk("reseq_sdram",    1,  1,  0,  1,  0,   1, 1,  0, 4'b0011, 1));
    vecs.push_back(mk("reseq_run",      1,  1,  0,  1,  0,   1, 0,  0, 4'b0011, 1));
    vecs.push_back(mk("clear_run",      1,  1,  0,  1,  1,   1, 0,  0, 4'b0000, 1));
    vecs.push_back(mk("ext_sync",       1,  1,  1,  1,  0,   2, 0,  0, 4'b0000, 1));
    vecs.push_back(mk("ext_hold",       1,  1,  1,  1,  0,   8, 1,  1, 4'b0100, 2));
    vecs.push_back(mk("ext_stretch",    1,  1,  0,  1,  0,  13, 1,  1, 4'b0100, 2));
    vecs.push_back(mk("ext_sdram",      1,  1,  0,  1,  0,   1, 1,  0, 4'b0100, 2));
    vecs.push_back(mk("ext_run",        1,  1,  0,  1,  0,   1, 0,  0, 4'b0100, 2));
    vecs.push_back(mk("loss2",          1,  0,  0,  1,  0,   1, 0,  0, 4'b0100, 2));
    vecs.push_back(mk("loss2_sync",     1,  1,  0,  1,  0,   1, 0,  0, 4'b0100, 2));
    vecs.push_back(mk("clr_with_loss",  1,  1,  0,  0,  1,   1, 1,  1, 4'b0010, 3));
    vecs.push_back(mk("clr_alone",      1,  1,  0,  0,  1,   1, 1,  1, 4'b0000, 3));
    vecs.push_back(mk("hold_wait",      1,  1,  0,  0,  0,  10, 1,  1, 4'b0000, 3));
    vecs.push_back(mk("init_again",     1,  1,  0,  0,  0,   1, 1,  0, 4'b0000, 3));
    vecs.push_back(mk("init_mid",       1,  1,  0,  0,  0,   3, 1,  0, 4'b0000, 3));

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; pll_locked = vecs[i].pll; ext_reset_req = vecs[i].ext;
      sdram_init_done = vecs[i].done; cause_clear = vecs[i].clr;
      step(vecs[i].cycles);
      check(vecs[i].name, {vecs[i].e_sys, vecs[i].e_sdram, vecs[i].e_cause, vecs[i].e_count});
    end

    // Asynchronous reset in the middle of SDRAM_INIT, observed without a clock edge.
    reset_n = 1'b0;
    #2;
    check("async_reset", {1'b1, 1'b1, 4'b0001, 8'd0});

    // Init timeout loop and reset_count saturation.
    reset_n = 1'b1; pll_locked = 1'b1; sdram_init_done = 1'b0;
    step(31);
    check("pre_timeout", {1'b1, 1'b0, 4'b0001, 8'd0});
    step(1);
    check("timeout_hold", {1'b1, 1'b1, 4'b1001, 8'd1});
    for (int k = 2; k <= 258; k++) begin
      step(32);
      check(k > 255 ? "count_sat" : "timeout_loop",
            {1'b1, 1'b1, 4'b1001, (k > 255) ? 8'd255 : 8'(k)});
    end

    // PLL lock toggling every 5 cycles never satisfies the lock run.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    ever_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      pll_locked = ((i / 5) % 2) == 0;
      step(1);
      if (!sdram_reset) ever_low = 1'b1;
    end
    n_cmp++;
    if (ever_low) begin
      n_err++;
      $display("FAIL toggle_sdram: sdram_reset released, required to stay 1");
    end
    check("toggle_end", {1'b1, 1'b1, 4'b0001, 8'd0});

    // Randomized traffic against the reference model.
    reset_n = 1'b0; pll_locked = 1'b1; ext_reset_req = 1'b0;
    sdram_init_done = 1'b0; cause_clear = 1'b0;
    model_reset();
    low_left = 2; pll_left = 0; ext_left = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      mexp = {m_ph != PH_RUN, (m_ph == PH_HOLD) || (m_ph == PH_LOCK), m_cause, 8'(m_cnt)};
      check("random", mexp);

      if (low_left > 0) low_left--;
      else if ($urandom_range(0, 599) == 0) low_left = $urandom_range(1, 3);
      if (pll_left > 0) pll_left--;
      else if ($urandom_range(0, 149) == 0) pll_left = $urandom_range(1, 12);
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 299) == 0) ext_left = $urandom_range(1, 8);
      pll_locked      = (pll_left == 0);
      ext_reset_req   = (ext_left != 0);
      sdram_init_done = ($urandom_range(0, 7) == 0);
      cause_clear     = ($urandom_range(0, 39) == 0);
      reset_n         = (low_left == 0);
      if (!reset_n) model_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
